// File: rtl/prim_subreg_shadow_stage_if.sv
// Bus bundle for the shadowed register stage: software write/read strobes,
// fault-injection mask, and the committed/staged values plus status flags.
interface prim_subreg_shadow_stage_if #(
   parameter int DW = 5
);
   logic          we_i;
   logic [DW-1:0] wd_i;
   logic          re_i;
   logic [DW-1:0] flip_i;
   logic [DW-1:0] q_o;
   logic [DW-1:0] qs_o;
   logic          phase_o;
   logic          commit_o;
   logic          err_update_o;
   logic          err_storage_o;

   modport master (
      output we_i, wd_i, re_i, flip_i,
      input  q_o, qs_o, phase_o, commit_o, err_update_o, err_storage_o
   );

   modport slave (
      input  we_i, wd_i, re_i, flip_i,
      output q_o, qs_o, phase_o, commit_o, err_update_o, err_storage_o
   );
endinterface

// File: rtl/prim_subreg_shadow_stage.sv
// Two-phase shadowed register core: a value commits only after two identical
// consecutive writes, and the committed copy is guarded by an inverted shadow.
module prim_subreg_shadow_stage #(
   parameter int            DW     = 5,
   parameter logic [DW-1:0] RESVAL = 5'b10101
) (
   input logic                      clk_i,
   input logic                      rst_i,
   prim_subreg_shadow_stage_if.slave bus
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STAGED = 1'b1
   } state_e;

   state_e        state_r;
   logic [DW-1:0] staged_r;
   logic [DW-1:0] committed_r;
   logic [DW-1:0] shadow_r;
   logic          commit_r;
   logic          err_update_r;
   logic          err_storage_r;

   // The shadow must always hold the exact bitwise inverse of the committed copy.
   function automatic logic storage_intact(input logic [DW-1:0] value,
                                           input logic [DW-1:0] shadow);
      return (value == ~shadow);
   endfunction

   // Write-phase FSM, committed/shadow storage and all status flops.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r       <= IDLE;
         staged_r      <= RESVAL;
         committed_r   <= RESVAL;
         shadow_r      <= ~RESVAL;
         commit_r      <= 1'b0;
         err_update_r  <= 1'b0;
         err_storage_r <= 1'b0;
      end else begin
         commit_r      <= 1'b0;
         err_update_r  <= 1'b0;
         err_storage_r <= err_storage_r | ~storage_intact(committed_r, shadow_r);
         shadow_r      <= shadow_r ^ bus.flip_i;
         case (state_r)
            IDLE: begin
               if (bus.we_i) begin
                  staged_r <= bus.wd_i;
                  state_r  <= STAGED;
               end else begin
                  state_r  <= IDLE;
               end
            end
            STAGED: begin
               if (bus.we_i) begin
                  // Write wins over a simultaneous read; a commit's flip lands on the fresh shadow.
                  if (bus.wd_i == staged_r) begin
                     committed_r <= bus.wd_i;
                     shadow_r    <= ~bus.wd_i ^ bus.flip_i;
                     commit_r    <= 1'b1;
                  end else begin
                     err_update_r <= 1'b1;
                  end
                  state_r <= IDLE;
               end else if (bus.re_i) begin
                  state_r <= IDLE;
               end else begin
                  state_r <= STAGED;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.q_o           = committed_r;
   assign bus.qs_o          = staged_r;
   assign bus.phase_o       = (state_r == STAGED);
   assign bus.commit_o      = commit_r;
   assign bus.err_update_o  = err_update_r;
   assign bus.err_storage_o = err_storage_r;

endmodule

// File: doc/prim_subreg_shadow_stage.md
Name: prim_subreg_shadow_stage

Overview:
Two-phase shadowed control-register core. It sits directly upstream of the plain register stage and feeds that stage's RESVAL-style value through q_o. A software write only commits after two identical consecutive writes. The committed value is protected by an inverted shadow copy, with update and storage error outputs. The commit logic runs only in that feeding stage; the downstream stage consumes q_o as its stored field value.

Parameters:
DW, 5, data width of the field
RESVAL, 5'b10101, reset value of the staged and committed copies; the shadow copy resets to ~RESVAL. Instantiators may pass an enum-typed value of width DW.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
we_i  in  1  write strobe, one write per asserted cycle
wd_i  in  DW  write data
re_i  in  1  read strobe; a read aborts a pending first-phase write
flip_i  in  DW  fault-injection mask XORed into the shadow copy on the cycle asserted (tie to 0 in mission mode)
q_o  out  DW  committed value, feeding the downstream register stage
qs_o  out  DW  staged value, for readback
phase_o  out  1  0 = IDLE, 1 = STAGED
commit_o  out  1  one-cycle pulse when a commit takes effect
err_update_o  out  1  one-cycle pulse on a mismatched second write
err_storage_o  out  1  sticky storage-integrity error

Behaviour:
- Internal state: staged_q, committed_q, shadow_q (stored inverted), FSM state, error flops.
- Reset (rst_i high at a clock edge, overrides all other inputs):
  - staged_q = committed_q = RESVAL; shadow_q = ~RESVAL.
  - FSM = IDLE.
  - commit_o = err_update_o = err_storage_o = 0.
  - Hence q_o = qs_o = RESVAL and phase_o = 0.
- FSM IDLE:
  - we_i: staged_q <= wd_i; go to STAGED.
  - re_i alone: no effect.
- FSM STAGED:
  - we_i with wd_i == staged_q:
    - committed_q <= wd_i; shadow_q <= ~wd_i.
    - commit_o = 1 for the next cycle; go to IDLE.
  - we_i with wd_i != staged_q:
    - committed_q and shadow_q unchanged; staged_q unchanged.
    - err_update_o = 1 for the next cycle; go to IDLE.
  - re_i without we_i: go to IDLE; staged_q unchanged; no error.
  - we_i and re_i in the same cycle: the write takes priority and re_i is ignored.
- Latency:
  - Second write sampled at edge N; q_o shows the new value after edge N (visible in cycle N+1).
  - commit_o and err_update_o are high during cycle N+1 only.
- Consecutive commits: a write in the cycle after a commit starts a new first phase normally. Back-to-back write pairs with no idle cycles are legal.
- Storage check:
  - err_storage_o <= 1 at any edge where committed_q != ~shadow_q. The comparison uses the registered values, so detection is 1 cycle after corruption.
  - err_storage_o stays set until reset. q_o keeps the committed_q value; there is no auto-correction.
- flip_i: on any edge with flip_i != 0, shadow_q <= shadow_q ^ flip_i.
  - If a commit happens in the same cycle, the flip applies to the new shadow value: ~wd_i ^ flip_i.
- err_update_o does not affect committed state and is never sticky.
- Widths: all compares are exact DW-bit compares; no arithmetic.

Test Plan:
- Reset: hold rst_i 2 cycles -> q_o = qs_o = 5'b10101, phase_o = 0, all error/commit outputs 0.
- Good commit: we_i with wd_i = 5'h1F, then next cycle we_i with 5'h1F -> phase_o = 1 after the first write; q_o = 5'h1F and commit_o = 1 for exactly one cycle after the second; phase_o = 0.
- Mismatch: write 5'h03 then 5'h04 -> err_update_o pulses once, q_o stays 5'b10101, qs_o = 5'h03, phase_o = 0; then write 5'h04 twice -> q_o = 5'h04, no error.
- Abort: write 5'h0A, pulse re_i, write 5'h0B -> phase_o = 1 (new first phase), q_o unchanged, no err_update_o; a second 5'h0B commits.
- Fault injection: after committing 5'h1F, pulse flip_i = 5'h01 for 1 cycle -> err_storage_o rises 1 cycle later and stays high through further good commits until rst_i.
- Priority and mid-operation reset: in STAGED, assert we_i (matching) with re_i -> commit occurs. In STAGED, assert rst_i -> phase_o = 0 and q_o = 5'b10101; a following single write does not commit.
